// File: rtl/kmkz_dbg_pkg.sv
// Shared types and constants for the debug UART bridge.
// Holds FSM encoding, command layout, notify byte, default divider.
package kmkz_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_STROBE    = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_TX_BUSY   = 3'd4
  } state_t;

  localparam int         CMD_WR_BIT  = 7;
  localparam logic [7:0] NOTIFY_BYTE = 8'hA5;
  localparam int         DEF_CLK_DIV = 868;

endpackage

// File: rtl/kmkz_dbg_uart_bridge_if.sv
// Byte-level handshake between the bridge FSM and the UART phy.
// master = command FSM side, slave = serialiser side.
interface kmkz_dbg_uart_bridge_if;

  logic [7:0] rx_dat;
  logic       rx_vld;
  logic       rx_ack;
  logic [7:0] tx_dat;
  logic       tx_load;
  logic       tx_busy;

  modport master (
    input  rx_dat, rx_vld, tx_busy,
    output rx_ack, tx_dat, tx_load
  );

  modport slave (
    output rx_dat, rx_vld, tx_busy,
    input  rx_ack, tx_dat, tx_load
  );

endinterface

// File: rtl/kmkz_uart_phy.sv
// 8N1 UART serialiser/deserialiser with a one-byte RX holding register.
// RX arms only after one full bit time of idle-high line.
module kmkz_uart_phy
  import kmkz_dbg_pkg::*;
#(
  parameter int g_clk_div = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic rxd,
  output logic txd,
  kmkz_dbg_uart_bridge_if.slave link
);

  localparam int CW = $clog2(g_clk_div + 1);
  localparam logic [CW-1:0] DIV_M1 = CW'(g_clk_div - 1);
  localparam logic [CW-1:0] HALF   = CW'(g_clk_div / 2);

  logic [2:0]    sync;
  logic          rx_line;
  logic          rx_prev;
  logic          armed;
  logic [CW-1:0] arm_cnt;
  logic          rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic [7:0]    rx_hold;
  logic          rx_full;
  logic          rx_smp;
  logic          rx_wrap;
  logic          rx_done;

  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;
  logic          txd_q;

  assign rx_line = sync[1];
  assign rx_prev = sync[2];
  assign rx_smp  = rx_busy && (rx_cnt == HALF);
  assign rx_wrap = (rx_cnt == DIV_M1);
  assign rx_done = rx_smp && (rx_bit == 4'd9) && rx_line;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync <= 3'b111;
    else          sync <= {sync[1:0], rxd};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (!armed) begin
      if (!rx_line)              arm_cnt <= '0;
      else if (arm_cnt == DIV_M1) armed  <= 1'b1;
      else                       arm_cnt <= arm_cnt + 1'b1;
    end
  end

  // Bit 0 is the start bit (re-checked mid-bit), 1..8 data, 9 stop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else if (!rx_busy) begin
      if (armed && rx_prev && !rx_line) begin
        rx_busy <= 1'b1;
        rx_cnt  <= CW'(1);
        rx_bit  <= '0;
      end
    end else begin
      rx_cnt <= rx_wrap ? '0 : rx_cnt + 1'b1;
      if (rx_wrap) rx_bit <= rx_bit + 1'b1;
      if (rx_smp) begin
        unique case (1'b1)
          (rx_bit == 4'd0): if (rx_line) rx_busy <= 1'b0;
          (rx_bit == 4'd9): rx_busy <= 1'b0;
          default:          rx_sh <= {rx_line, rx_sh[7:1]};
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_hold <= '0;
      rx_full <= 1'b0;
    end else if (rx_done && (!rx_full || link.rx_ack)) begin
      rx_hold <= rx_sh;
      rx_full <= 1'b1;
    end else if (link.rx_ack) begin
      rx_full <= 1'b0;
    end
  end

  assign link.rx_dat = rx_hold;
  assign link.rx_vld = rx_full;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
      txd_q   <= 1'b1;
    end else if (!tx_busy) begin
      if (link.tx_load) begin
        tx_busy <= 1'b1;
        tx_sh   <= {1'b1, link.tx_dat};
        txd_q   <= 1'b0;
        tx_cnt  <= '0;
        tx_bit  <= '0;
      end
    end else if (tx_cnt == DIV_M1) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        txd_q   <= 1'b1;
      end else begin
        tx_bit <= tx_bit + 1'b1;
        txd_q  <= tx_sh[0];
        tx_sh  <= {1'b1, tx_sh[8:1]};
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign txd          = txd_q;
  assign link.tx_busy = tx_busy;

endmodule

// File: rtl/kmkz_dbg_uart_bridge.sv
// Host UART to debug-register bridge: command byte, optional data byte, read reply.
// Define KMKZ_DBG_UART_IRQ_NOTIFY_EN to send 0xA5 on dbg_irq_i rising edges.
module kmkz_dbg_uart_bridge
  import kmkz_dbg_pkg::*;
#(
  parameter int g_clk_div    = DEF_CLK_DIV,
  parameter int g_rx_timeout = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       uart_rxd_i,
  output logic       uart_txd_o,
  output logic [6:0] dbg_adr_o,
  output logic [7:0] dbg_dat_o,
  output logic       dbg_stb_o,
  output logic       dbg_we_o,
  input  logic [7:0] dbg_dat_i,
  input  logic       dbg_irq_i
);

  localparam int TW = $clog2(g_rx_timeout + 1);
  localparam logic [TW-1:0] TO_M1 = TW'(g_rx_timeout - 1);

  kmkz_dbg_uart_bridge_if link ();

  kmkz_uart_phy #(.g_clk_div(g_clk_div)) u_phy (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .rxd     (uart_rxd_i),
    .txd     (uart_txd_o),
    .link    (link.slave)
  );

  state_t        state;
  state_t        nxt;
  logic [6:0]    cmd_adr;
  logic [TW-1:0] to_cnt;
  logic          pend;
  logic          notify_go;
  logic          to_exp;

  logic          rx_ack;
  logic          tx_load;
  logic [7:0]    tx_dat;
  logic          ld_cmd;
  logic          ld_rd;
  logic          ld_wr;
  logic          pend_clr;

  assign notify_go = pend && !link.tx_busy;
  assign to_exp    = (to_cnt == TO_M1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (notify_go)
          nxt = ST_TX_BUSY;
        else if (link.rx_vld)
          nxt = link.rx_dat[CMD_WR_BIT] ? ST_WAIT_DATA : ST_STROBE;
      end
      ST_WAIT_DATA: begin
        if (link.rx_vld) nxt = ST_STROBE;
        else if (to_exp) nxt = ST_IDLE;
      end
      ST_STROBE:  nxt = dbg_we_o ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: nxt = ST_TX_BUSY;
      ST_TX_BUSY: if (!link.tx_busy) nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_ack   = 1'b0;
    tx_load  = 1'b0;
    tx_dat   = '0;
    ld_cmd   = 1'b0;
    ld_rd    = 1'b0;
    ld_wr    = 1'b0;
    pend_clr = 1'b0;
    dbg_stb_o = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (notify_go) begin
          tx_load  = 1'b1;
          tx_dat   = NOTIFY_BYTE;
          pend_clr = 1'b1;
        end else if (link.rx_vld) begin
          rx_ack = 1'b1;
          ld_cmd = link.rx_dat[CMD_WR_BIT];
          ld_rd  = !link.rx_dat[CMD_WR_BIT];
        end
      end
      ST_WAIT_DATA: begin
        rx_ack = link.rx_vld;
        ld_wr  = link.rx_vld;
      end
      ST_STROBE: dbg_stb_o = 1'b1;
      ST_CAPTURE: begin
        tx_load = 1'b1;
        tx_dat  = dbg_dat_i;
      end
      default: ;
    endcase
  end

  assign link.rx_ack  = rx_ack;
  assign link.tx_load = tx_load;
  assign link.tx_dat  = tx_dat;

  // Bus outputs change only when an access is launched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_adr   <= '0;
      dbg_adr_o <= '0;
      dbg_dat_o <= '0;
      dbg_we_o  <= 1'b0;
    end else begin
      if (ld_cmd) cmd_adr <= link.rx_dat[6:0];
      if (ld_rd) begin
        dbg_adr_o <= link.rx_dat[6:0];
        dbg_we_o  <= 1'b0;
      end
      if (ld_wr) begin
        dbg_adr_o <= cmd_adr;
        dbg_dat_o <= link.rx_dat;
        dbg_we_o  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                   to_cnt <= '0;
    else if (state == ST_WAIT_DATA) to_cnt <= to_cnt + 1'b1;
    else                            to_cnt <= '0;
  end

`ifdef KMKZ_DBG_UART_IRQ_NOTIFY_EN
  logic irq_q;

  // A new edge in the same cycle as the clear re-arms the flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_q <= dbg_irq_i;
      if (dbg_irq_i && !irq_q) pend <= 1'b1;
      else if (pend_clr)       pend <= 1'b0;
    end
  end
`else
  logic unused_notify;

  assign pend          = 1'b0;
  assign unused_notify = dbg_irq_i ^ pend_clr;
`endif

endmodule

// File: tb/tb_kmkz_dbg_uart_bridge.sv
// Directed bench for kmkz_dbg_uart_bridge with strobe and TX scoreboards.
// Expectations follow KMKZ_DBG_UART_IRQ_NOTIFY_EN when defined.
module tb_kmkz_dbg_uart_bridge;

  localparam int DIV = 16;
  localparam int TMO = 2000;

  typedef struct {
    logic       we;
    logic [6:0] adr;
    logic [7:0] dat;
  } stb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       txd;
  logic [6:0] adr;
  logic [7:0] dat;
  logic       stb;
  logic       we;
  logic [7:0] rdat = 8'h00;
  logic       irq;
  logic [7:0] rd_val = 8'h00;

  int errors = 0;
  int checks = 0;
  int stb_cnt = 0;
  int tx_frames = 0;
  logic stb_prev = 1'b0;
  logic tx_active = 1'b0;

  stb_t       exp_stb[$];
  logic [7:0] exp_tx[$];

  kmkz_dbg_uart_bridge_if mon ();

  kmkz_dbg_uart_bridge #(
    .g_clk_div    (DIV),
    .g_rx_timeout (TMO)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .uart_rxd_i (rxd),
    .uart_txd_o (txd),
    .dbg_adr_o  (adr),
    .dbg_dat_o  (dat),
    .dbg_stb_o  (stb),
    .dbg_we_o   (we),
    .dbg_dat_i  (rdat),
    .dbg_irq_i  (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (stb && !we) rdat <= rd_val;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  stb_t se;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && stb === 1'b1) begin
      stb_cnt++;
      chk("stb_one_cycle", 32'(stb_prev), 32'd0);
      chk("stb_expected", 32'(exp_stb.size() != 0), 32'd1);
      if (exp_stb.size() != 0) begin
        se = exp_stb.pop_front();
        chk("stb_we", 32'(we), 32'(se.we));
        chk("stb_adr", 32'(adr), 32'(se.adr));
        if (se.we) chk("stb_dat", 32'(dat), 32'(se.dat));
      end
    end
    stb_prev = stb;
  end

  logic [7:0] eb;
  logic [7:0] got;
  logic [9:0] frm;
  int         bad;
  logic       aborted;
  initial begin
    mon.rx_dat = '0; mon.rx_vld = 1'b0; mon.rx_ack = 1'b0;
    mon.tx_dat = '0; mon.tx_load = 1'b0; mon.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      mon.rx_vld = 1'b0;
      if (rst_n === 1'b1 && txd === 1'b0) begin
        tx_active = 1'b1;
        aborted = 1'b0;
        bad = 0;
        got = '0;
        chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
        eb = (exp_tx.size() != 0) ? exp_tx.pop_front() : 8'h00;
        frm = {1'b1, eb, 1'b0};
        for (int i = 0; i < 10 * DIV; i++) begin
          if (i > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (txd !== frm[i / DIV]) bad++;
          if (i % DIV == DIV / 2 && i >= DIV && i < 9 * DIV)
            got[i / DIV - 1] = txd;
        end
        tx_active = 1'b0;
        if (!aborted) begin
          chk("tx_byte", 32'(got), 32'(eb));
          chk("tx_frame_bits", 32'(bad), 32'd0);
          tx_frames++;
          mon.rx_dat = got;
          mon.rx_vld = 1'b1;
        end else begin
          wait (rst_n === 1'b1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_stb(input logic w, input logic [6:0] a,
                          input logic [7:0] d);
    stb_t s;
    s.we = w; s.adr = a; s.dat = d;
    exp_stb.push_back(s);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_stb.size() != 0 || exp_tx.size() != 0 || tx_active)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_stb_left"}, 32'(exp_stb.size()), 32'd0);
    chk({tag, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    repeat (300) @(negedge clk);
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (!tx_active && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(tx_active), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txd"}, 32'(txd), 32'd1);
    chk({tag, "_stb"}, 32'(stb), 32'd0);
    chk({tag, "_we"}, 32'(we), 32'd0);
    chk({tag, "_adr"}, 32'(adr), 32'd0);
    chk({tag, "_dat"}, 32'(dat), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  int s0;
  int f0;
  initial begin
    rst_n = 1'b0;
    rxd = 1'b1;
    irq = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    repeat (3 * DIV) @(negedge clk);

    push_stb(1'b1, 7'h05, 8'h3C);
    send_byte(8'h85, 1'b1);
    send_byte(8'h3C, 1'b1);
    drain("wr", 500);
    chk("wr_no_tx", 32'(tx_frames), 32'd0);
    chk("hold_we", 32'(we), 32'd1);
    chk("hold_adr", 32'(adr), 32'h05);
    chk("hold_dat", 32'(dat), 32'h3C);

    rd_val = 8'h7E;
    push_stb(1'b0, 7'h02, 8'h00);
    exp_tx.push_back(8'h7E);
    send_byte(8'h02, 1'b1);
    drain("rd", 1000);
    chk("rd_hold_dat", 32'(dat), 32'h3C);
    chk("rd_hold_we", 32'(we), 32'd0);

    s0 = stb_cnt;
    send_byte(8'h81, 1'b1);
    repeat (TMO + 100) @(negedge clk);
    chk("tmo_no_stb", 32'(stb_cnt), 32'(s0));
    rd_val = 8'h11;
    push_stb(1'b0, 7'h03, 8'h00);
    exp_tx.push_back(8'h11);
    send_byte(8'h03, 1'b1);
    drain("tmo_rd", 1000);

    s0 = stb_cnt;
    f0 = tx_frames;
    send_byte(8'h04, 1'b0);
    repeat (300) @(negedge clk);
    chk("ferr_no_stb", 32'(stb_cnt), 32'(s0));
    chk("ferr_no_tx", 32'(tx_frames), 32'(f0));
    rd_val = 8'h5A;
    push_stb(1'b0, 7'h04, 8'h00);
    exp_tx.push_back(8'h5A);
    send_byte(8'h04, 1'b1);
    drain("ferr_rd", 1000);

    f0 = tx_frames;
    rd_val = 8'hC3;
    push_stb(1'b0, 7'h01, 8'h00);
    exp_tx.push_back(8'hC3);
`ifdef KMKZ_DBG_UART_IRQ_NOTIFY_EN
    exp_tx.push_back(8'hA5);
`endif
    send_byte(8'h01, 1'b1);
    wait_tx("irq_tx_start");
    repeat (20) @(negedge clk);
    irq = 1'b1;
    repeat (3) @(negedge clk);
    irq = 1'b0;
    repeat (10) @(negedge clk);
    irq = 1'b1;
    repeat (3) @(negedge clk);
    irq = 1'b0;
    drain("irq", 1500);
    repeat (200) @(negedge clk);
`ifdef KMKZ_DBG_UART_IRQ_NOTIFY_EN
    chk("irq_frames", 32'(tx_frames), 32'(f0 + 2));
`else
    chk("irq_frames", 32'(tx_frames), 32'(f0 + 1));
`endif

    rd_val = 8'h7E;
    push_stb(1'b0, 7'h02, 8'h00);
    exp_tx.push_back(8'h7E);
    send_byte(8'h02, 1'b1);
    wait_tx("mid_tx_start");
    repeat (8) @(negedge clk);
    chk("pre_rst_txd", 32'(txd), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid_rst");
    exp_stb.delete();
    exp_tx.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * DIV) @(negedge clk);

    f0 = tx_frames;
    push_stb(1'b1, 7'h7F, 8'h12);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    rd_val = 8'h99;
    push_stb(1'b0, 7'h06, 8'h00);
    exp_tx.push_back(8'h99);
    send_byte(8'h06, 1'b1);
    drain("post_rst", 1000);
    chk("post_rst_frames", 32'(tx_frames), 32'(f0 + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
